// File: rtl/adder_result_collector_if.sv
// Handshake bundle between the operand source/adder/consumer and the result collector.
interface adder_result_collector_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 8
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned InfW = $clog2(LATENCY + 1);

  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic [CntW-1:0]  count;
  logic [InfW-1:0]  inflight;
  logic             overflow_err;

  // Environment side: operand source, adder outputs and result consumer.
  modport master (
    output issue_valid, sum, cout, out_ready,
    input  issue_ready, out_valid, out_data, count, inflight, overflow_err
  );

  // Collector side.
  modport slave (
    input  issue_valid, sum, cout, out_ready,
    output issue_ready, out_valid, out_data, count, inflight, overflow_err
  );
endinterface

// File: rtl/adder_result_collector.sv
// Collects {cout,sum} from a fixed-latency, flow-control-free adder into a FWFT FIFO and
// throttles operand issue with credits so no result is ever dropped.
module adder_result_collector #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 8
) (
  input logic                    clk,
  input logic                    reset,
  adder_result_collector_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned InfW = $clog2(LATENCY + 1);
  localparam int unsigned CrdW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [InfW-1:0]    inflight_q, inflight_d;
  logic               overflow_q, overflow_d;
  logic [WIDTH:0]     mem_q [DEPTH];

  logic            issue_ready;
  logic            issue_fire;
  logic            capture;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic [CrdW-1:0] credit_used;

  // Credit accounting and handshake decode; issue_ready depends on registered state only.
  always_comb begin
    credit_used = CrdW'(count_q) + CrdW'(inflight_q);
    issue_ready = credit_used < CrdW'(DEPTH);
    issue_fire  = bus.issue_valid & issue_ready;
    capture     = pipe_q[LATENCY-1];
    full        = (count_q == CntW'(DEPTH));
    pop         = (count_q != '0) & bus.out_ready;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    wr_en       = capture & (~full | pop);
  end

  // Next-state for the issue pipe, pointers, occupancy, in-flight count and error flag.
  always_comb begin
    pipe_d     = pipe_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    overflow_d = overflow_q;

    pipe_d[0] = issue_fire;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (wr_en) begin
      wr_ptr_d = PtrW'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      rd_ptr_d = PtrW'(rd_ptr_q + 1'b1);
    end

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    unique case ({issue_fire, capture})
      2'b10:   inflight_d = inflight_q + InfW'(1);
      2'b01:   inflight_d = inflight_q - InfW'(1);
      default: inflight_d = inflight_q;
    endcase

    // Only reachable if the adder latency disagrees with LATENCY.
    if (capture && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      pipe_q     <= pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  // Result storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= {bus.cout, bus.sum};
    end
  end

  assign bus.issue_ready  = issue_ready;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_data     = mem_q[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.inflight     = inflight_q;
  assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_adder_result_collector.sv
// Bench for adder_result_collector: behavioural 3-stage adder, queue scoreboard,
// directed scenarios followed by a randomized stall run.
module tb_adder_result_collector;
  localparam int unsigned Width   = 16;
  localparam int unsigned Latency = 3;
  localparam int unsigned Depth   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_result_collector_if #(.WIDTH(Width), .LATENCY(Latency), .DEPTH(Depth)) bus ();

  adder_result_collector #(.WIDTH(Width), .LATENCY(Latency), .DEPTH(Depth)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural pipelined adder with no flow control.
  logic [15:0] a, b;
  logic        cin;
  logic [16:0] st_q [Latency];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Latency; i++) st_q[i] <= '0;
    end else begin
      st_q[0] <= {1'b0, a} + {1'b0, b} + {16'b0, cin};
      for (int i = 1; i < Latency; i++) st_q[i] <= st_q[i-1];
    end
  end
  assign bus.sum  = st_q[Latency-1][15:0];
  assign bus.cout = st_q[Latency-1][16];

  int tests  = 0;
  int failed = 0;
  int n_pop  = 0;
  logic [16:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard bookkeeping at the sampling point, then advance one cycle.
  task automatic tick();
    logic [16:0] head;
    // Outstanding = issued but not yet popped; credit is available below Depth.
    check("credit", 32'(bus.issue_ready), 32'(exp_q.size() < Depth));
    if (bus.out_valid && bus.out_ready) begin
      n_pop++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        check("sb_data", 32'(bus.out_data), 32'(head));
      end
    end
    if (bus.issue_valid && bus.issue_ready) begin
      exp_q.push_back({1'b0, a} + {1'b0, b} + {16'b0, cin});
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int guard;
    int pops0;
    logic fire;

    reset = 1'b1;
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(bus.count), 0);
    check("rst_inflight", 32'(bus.inflight), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_issue_ready", 32'(bus.issue_ready), 1);
    check("rst_overflow", 32'(bus.overflow_err), 0);

    // Single transaction: 0xFFFF + 0x0001 -> 0x1_0000 after LATENCY+1 cycles
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("single_inflight", 32'(bus.inflight), 1);
      check("single_no_valid", 32'(bus.out_valid), 0);
      tick();
    end
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_data", 32'(bus.out_data), 32'h1_0000);
    check("single_count", 32'(bus.count), 1);
    check("single_inflight0", 32'(bus.inflight), 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("single_popped", 32'(bus.count), 0);

    // Back-pressure: exactly Depth issues accepted, stored in order
    bus.issue_valid = 1'b1;
    k = 0;
    repeat (14) begin
      a = 16'(k); b = 16'(k); cin = 1'b0;
      fire = bus.issue_ready;
      tick();
      if (fire) k++;
    end
    bus.issue_valid = 1'b0;
    check("bp_accepted", 32'(k), 8);
    check("bp_count", 32'(bus.count), 8);
    check("bp_inflight", 32'(bus.inflight), 0);
    check("bp_ready_low", 32'(bus.issue_ready), 0);
    check("bp_overflow", 32'(bus.overflow_err), 0);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("bp_order", 32'(bus.out_data), 32'(2 * j));
      tick();
    end
    bus.out_ready = 1'b0;
    check("bp_drained", 32'(bus.count), 0);

    // Full FIFO with push and pop on the same edge
    bus.issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      tick();
    end
    bus.issue_valid = 1'b0;
    tick();
    tick();
    check("full_count7", 32'(bus.count), 7);
    check("full_inflight1", 32'(bus.inflight), 1);
    bus.out_ready = 1'b1;
    tick();
    check("full_count_held", 32'(bus.count), 7);
    check("full_inflight0", 32'(bus.inflight), 0);
    check("full_overflow", 32'(bus.overflow_err), 0);
    guard = 0;
    while (bus.out_valid && guard < 20) begin
      tick();
      guard++;
    end
    bus.out_ready = 1'b0;
    check("full_drained", 32'(bus.count), 0);
    check("full_sb_empty", 32'(exp_q.size()), 0);

    // Streaming with pointer wrap; cin on odd k produces carry-out at k=15
    bus.out_ready = 1'b1;
    bus.issue_valid = 1'b1;
    pops0 = n_pop;
    for (int s = 0; s < 20; s++) begin
      a = 16'(32'h1000 * s); b = 16'h0FFF; cin = s[0];
      check("stream_ready", 32'(bus.issue_ready), 1);
      tick();
    end
    bus.issue_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      tick();
      guard++;
    end
    check("stream_outputs", 32'(n_pop - pops0), 20);
    check("stream_count", 32'(bus.count), 0);
    bus.out_ready = 1'b0;

    // Reset with results both stored and in flight
    bus.issue_valid = 1'b1;
    repeat (5) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      tick();
    end
    bus.issue_valid = 1'b0;
    check("mid_count", 32'(bus.count), 2);
    check("mid_inflight", 32'(bus.inflight), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_inflight", 32'(bus.inflight), 0);
    check("mrst_out_valid", 32'(bus.out_valid), 0);
    check("mrst_issue_ready", 32'(bus.issue_ready), 1);
    repeat (4) begin
      tick();
      check("mrst_no_capture", 32'(bus.count), 0);
    end

    // Random issue/stall against the scoreboard
    for (int cyc = 0; cyc < 1000; cyc++) begin
      bus.issue_valid = ($urandom_range(0, 3) != 0);
      if (((cyc / 100) % 2) == 0) bus.out_ready = ($urandom_range(0, 3) == 0);
      else bus.out_ready = ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      tick();
    end
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    check("rand_sb_empty", 32'(exp_q.size()), 0);
    check("rand_count", 32'(bus.count), 0);
    check("rand_overflow", 32'(bus.overflow_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/adder_result_collector.md
Name: adder_result_collector

Overview:
Downstream stage of the team's 16-bit pipelined ripple adder (operand-to-sum latency 3 cycles). The adder has no flow control. This block tracks which issue slots carry real operands and captures each {cout,sum} result into a small FIFO, which it presents on a valid/ready output port. It back-pressures the operand source with credit logic so a result is never dropped.

Parameters:
WIDTH, 16, adder operand/sum width
LATENCY, 3, cycles from operand issue edge to sum/cout valid at this block's inputs; >=1
DEPTH, 8, result FIFO entries; power of 2, >=2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  reset, synchronous, active-high
issue_valid  input  1  source presents operands to the adder this cycle
issue_ready  output  1  collector can accept one more result; issue fires when issue_valid & issue_ready
sum  input  WIDTH  adder sum output
cout  input  1  adder carry output
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  WIDTH+1  {cout,sum} of FIFO head
count  output  clog2(DEPTH+1)  entries currently stored
inflight  output  clog2(LATENCY+1)  issued results not yet captured
overflow_err  output  1  sticky: write attempted into full FIFO without a simultaneous pop

Behaviour:
- Reset (sync, highest priority): clear the valid shift pipe, read/write pointers, count, inflight and overflow_err. Outputs after reset: out_valid=0, count=0, inflight=0, overflow_err=0, issue_ready=1, out_data don't-care. Results already in the adder when reset is applied are discarded; the adder's reset is asserted in the same cycle.
- Issue tracking: a LATENCY-bit shift register. Bit 0 loads (issue_valid & issue_ready) each cycle; the tail bit marks the cycle in which sum/cout are sampled. inflight = number of set bits in the pipe, maintained as a counter: +1 on issue, -1 on capture, unchanged on both.
- Capture (push): on a rising edge with the tail bit set, write {cout,sum} at the write pointer. Idle slots never write.
- issue_ready = (count + inflight) < DEPTH. It is a function of registered state only: no combinational path from issue_valid or out_ready. A pop in cycle t frees credit from t+1 (conservative by design).
- Output: first-word-fall-through. out_valid = (count != 0). out_data = entry at the read pointer. Pop when out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- No bypass: a result captured into an empty FIFO appears on out_valid on the next cycle. Minimum issue-to-out_valid latency is LATENCY+1 cycles.
- Simultaneous push and pop: both happen, count unchanged. This is legal at count=DEPTH (the pop frees the slot being written).
- Push at count=DEPTH with no pop: data dropped, pointers and count unchanged, overflow_err set until reset. Unreachable under the credit rule; it flags a LATENCY mismatch.
- Pop at count=0: ignored.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Full/empty are decided from count, not pointer comparison.
- Throughput: with out_ready held at 1, one issue per cycle is sustained indefinitely.

Test Plan:
- Single transaction: bench instantiates the 16-bit adder (LATENCY=3). Issue a=0xFFFF, b=0x0001, cin=0 at cycle 0 -> inflight=1 for cycles 1-3, out_valid=1 at cycle 4 with out_data=0x1_0000, count=1; pop -> count=0.
- Back-pressure: out_ready=0, issue_valid=1 continuously with a=n, b=n -> exactly 8 issues accepted; issue_ready=0 from the cycle count+inflight reaches 8; FIFO holds 2n for n=0..7 in order; overflow_err=0.
- Full with simultaneous push/pop: fill to count=7 with one in flight, assert out_ready on the capture cycle -> count stays 7 then drains in order; no data lost.
- Streaming wrap-around: 20 back-to-back issues a=0x1000*k, b=0x0FFF, out_ready=1 -> 20 outputs in order, each {carry,(0x1000*k+0x0FFF)} including carry-out cases; pointers wrap twice; issue_ready never drops.
- Reset mid-operation: 3 issues in flight and 2 stored, assert reset one cycle -> next cycle count=0, inflight=0, out_valid=0, issue_ready=1; the adder's pending results produce no captures.
- Random stall: random issue_valid/out_ready for 1000 cycles against a scoreboard -> every issued result emerges once, in order; overflow_err stays 0.
